// File: rtl/alu_unit.sv
// Single-stage 32-bit integer ALU (add, subtract, multiply, unsigned divide) with a one-hot opcode.
// Result and status flags are computed combinationally and registered together on each rising edge.
module alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] output1,
    output logic             zero,
    output logic             carry,
    output logic             error
);

    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0001;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_divisor;
    logic [WIDTH-1:0]     w_quot;
    logic                 w_div_by_zero;
    logic [WIDTH-1:0]     w_result;
    logic                 w_carry;
    logic                 w_error;
    logic                 w_zero;

    logic [WIDTH-1:0]     r_output1;
    logic                 r_zero;
    logic                 r_carry;
    logic                 r_error;

    // Arithmetic datapath and opcode decode for the value to be registered
    always_comb begin
        w_sum         = {1'b0, input1} + {1'b0, input2};
        w_diff        = {1'b0, input1} - {1'b0, input2};
        w_prod        = {{WIDTH{1'b0}}, input1} * {{WIDTH{1'b0}}, input2};
        w_div_by_zero = (input2 == {WIDTH{1'b0}});
        // Substitute a divisor of one so the divider never sees zero; the result is overridden below
        w_divisor     = w_div_by_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : input2;
        w_quot        = input1 / w_divisor;
        w_result      = {WIDTH{1'b0}};
        w_carry       = 1'b0;
        w_error       = 1'b0;
        case (op)
            OP_ADD: begin
                w_result = w_sum[WIDTH-1:0];
                w_carry  = w_sum[WIDTH];
                w_error  = 1'b0;
            end
            OP_SUB: begin
                w_result = w_diff[WIDTH-1:0];
                w_carry  = w_diff[WIDTH];
                w_error  = 1'b0;
            end
            OP_MUL: begin
                w_result = w_prod[WIDTH-1:0];
                w_carry  = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
                w_error  = 1'b0;
            end
            OP_DIV: begin
                if (w_div_by_zero) begin
                    w_result = {WIDTH{1'b1}};
                    w_error  = 1'b1;
                end else begin
                    w_result = w_quot;
                    w_error  = 1'b0;
                end
                w_carry = 1'b0;
            end
            default: begin
                w_result = {WIDTH{1'b0}};
                w_carry  = 1'b0;
                w_error  = 1'b1;
            end
        endcase
        w_zero = (w_result == {WIDTH{1'b0}});
    end

    // Output register; reset clears everything, including zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_output1 <= {WIDTH{1'b0}};
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_output1 <= w_result;
            r_zero    <= w_zero;
            r_carry   <= w_carry;
            r_error   <= w_error;
        end
    end

    assign output1 = r_output1;
    assign zero    = r_zero;
    assign carry   = r_carry;
    assign error   = r_error;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vectors plus randomized traffic against a reference model.
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] input1;
    logic [31:0] input2;
    logic [3:0]  op;
    logic [31:0] output1;
    logic        zero;
    logic        carry;
    logic        error;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  o;
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        e;
    } vec_t;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        e;
    } exp_t;

    always #5 clk = ~clk;

    alu_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .input1  (input1),
        .input2  (input2),
        .op      (op),
        .output1 (output1),
        .zero    (zero),
        .carry   (carry),
        .error   (error)
    );

    // Reference: plain 64-bit arithmetic straight from the operation definitions
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] o);
        exp_t            x;
        longint unsigned la;
        longint unsigned lb;
        longint unsigned full;
        la = {32'd0, a};
        lb = {32'd0, b};
        x  = '0;
        if (o == 4'b1000) begin
            full = la + lb;
            x.r  = full[31:0];
            x.c  = (full > 64'h0000_0000_FFFF_FFFF);
        end else if (o == 4'b0100) begin
            full = la - lb;
            x.r  = full[31:0];
            x.c  = (a < b);
        end else if (o == 4'b0010) begin
            full = la * lb;
            x.r  = full[31:0];
            x.c  = (full >= 64'h0000_0001_0000_0000);
        end else if (o == 4'b0001) begin
            if (b == 32'd0) begin
                x.r = 32'hFFFF_FFFF;
                x.e = 1'b1;
            end else begin
                full = la / lb;
                x.r  = full[31:0];
            end
        end else begin
            x.r = 32'd0;
            x.e = 1'b1;
        end
        x.z = (x.r == 32'd0);
        return x;
    endfunction

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [3:0] o);
        @(negedge clk);
        input1 = a;
        input2 = b;
        op     = o;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        input1 = 32'd5;
        input2 = 32'd3;
        op     = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({output1, zero, carry, error} !== {32'd0, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got out=%h z=%b c=%b e=%b, want all zero", i, output1, zero, carry, error);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({output1, zero, carry, error} !== {32'd8, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release: got out=%h z=%b c=%b e=%b, want out=00000008 z=0 c=0 e=0", output1, zero, carry, error);
        end
    endtask

    task automatic test_add_sub();
        vec_t v[4];
        v[0] = '{32'd2, 32'd4, 4'b1000, 32'd6, 1'b0, 1'b0, 1'b0};
        v[1] = '{32'd4, 32'd2, 4'b0100, 32'd2, 1'b0, 1'b0, 1'b0};
        v[2] = '{32'd2, 32'd4, 4'b0100, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0};
        v[3] = '{32'hFFFF_FFFF, 32'd1, 4'b1000, 32'd0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            apply(v[i].a, v[i].b, v[i].o);
            n_cmp++;
            if ({output1, zero, carry, error} !== {v[i].r, v[i].z, v[i].c, v[i].e}) begin
                n_fail++;
                $display("FAIL add_sub[%0d]: got out=%h z=%b c=%b e=%b, want out=%h z=%b c=%b e=%b",
                         i, output1, zero, carry, error, v[i].r, v[i].z, v[i].c, v[i].e);
            end
        end
    endtask

    task automatic test_mul_div();
        vec_t v[4];
        v[0] = '{32'd6, 32'd4, 4'b0010, 32'h18, 1'b0, 1'b0, 1'b0};
        v[1] = '{32'd8, 32'd2, 4'b0001, 32'd4, 1'b0, 1'b0, 1'b0};
        v[2] = '{32'h0001_0000, 32'h0001_0000, 4'b0010, 32'd0, 1'b1, 1'b1, 1'b0};
        v[3] = '{32'd7, 32'd2, 4'b0001, 32'd3, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            apply(v[i].a, v[i].b, v[i].o);
            n_cmp++;
            if ({output1, zero, carry, error} !== {v[i].r, v[i].z, v[i].c, v[i].e}) begin
                n_fail++;
                $display("FAIL mul_div[%0d]: got out=%h z=%b c=%b e=%b, want out=%h z=%b c=%b e=%b",
                         i, output1, zero, carry, error, v[i].r, v[i].z, v[i].c, v[i].e);
            end
        end
    endtask

    task automatic test_div_zero();
        vec_t v[2];
        v[0] = '{32'd9, 32'd0, 4'b0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
        v[1] = '{32'd1, 32'd1, 4'b1000, 32'd2, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 2; i++) begin
            apply(v[i].a, v[i].b, v[i].o);
            n_cmp++;
            if ({output1, zero, carry, error} !== {v[i].r, v[i].z, v[i].c, v[i].e}) begin
                n_fail++;
                $display("FAIL div_zero[%0d]: got out=%h z=%b c=%b e=%b, want out=%h z=%b c=%b e=%b",
                         i, output1, zero, carry, error, v[i].r, v[i].z, v[i].c, v[i].e);
            end
        end
    endtask

    task automatic test_illegal();
        logic [3:0] ops[4];
        ops[0] = 4'b0000;
        ops[1] = 4'b1100;
        ops[2] = 4'b1111;
        ops[3] = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            apply(32'd5, 32'd3, ops[i]);
            n_cmp++;
            if ({output1, zero, carry, error} !== {32'd0, 1'b1, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL illegal[op=%b]: got out=%h z=%b c=%b e=%b, want out=00000000 z=1 c=0 e=1",
                         ops[i], output1, zero, carry, error);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops[4];
        logic [31:0] a;
        logic [31:0] b;
        exp_t        prev;
        exp_t        cur;
        ops[0] = 4'b1000;
        ops[1] = 4'b0100;
        ops[2] = 4'b0010;
        ops[3] = 4'b0001;
        apply(32'd11, 32'd22, 4'b1000);
        prev = model(32'd11, 32'd22, 4'b1000);
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom_range(1, 1000);
            cur = model(a, b, ops[i]);
            @(negedge clk);
            input1 = a;
            input2 = b;
            op     = ops[i];
            #1;
            n_cmp++;
            if ({output1, zero, carry, error} !== prev) begin
                n_fail++;
                $display("FAIL b2b_hold[%0d]: got %h_%b%b%b before edge, want %h_%b%b%b",
                         i, output1, zero, carry, error, prev.r, prev.z, prev.c, prev.e);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if ({output1, zero, carry, error} !== cur) begin
                n_fail++;
                $display("FAIL b2b_update[%0d]: got %h_%b%b%b, want %h_%b%b%b",
                         i, output1, zero, carry, error, cur.r, cur.z, cur.c, cur.e);
            end
            prev = cur;
        end
    endtask

    task automatic test_random();
        logic [3:0]  ops[7];
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  o;
        exp_t        x;
        ops[0] = 4'b1000;
        ops[1] = 4'b0100;
        ops[2] = 4'b0010;
        ops[3] = 4'b0001;
        ops[4] = 4'b0000;
        ops[5] = 4'b1010;
        ops[6] = 4'b0001;
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 255);
                2:       b = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 4);
            o = ops[$urandom_range(0, 6)];
            x = model(a, b, o);
            apply(a, b, o);
            n_cmp++;
            if ({output1, zero, carry, error} !== x) begin
                n_fail++;
                $display("FAIL random[%0d] a=%h b=%h op=%b: got %h_%b%b%b, want %h_%b%b%b",
                         i, a, b, o, output1, zero, carry, error, x.r, x.z, x.c, x.e);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t x;
        apply(32'hFFFF_FFF0, 32'h20, 4'b1000);
        n_cmp++;
        if ({output1, zero, carry, error} !== {32'h10, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL async_pre: got %h_%b%b%b, want 00000010_010", output1, zero, carry, error);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({output1, zero, carry, error} !== {32'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_clear: got %h_%b%b%b without edge, want 00000000_000", output1, zero, carry, error);
        end
        @(negedge clk);
        input1 = 32'd0;
        input2 = 32'd0;
        op     = 4'b0000;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({output1, zero, carry, error} !== {32'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_held: got %h_%b%b%b, want 00000000_000", output1, zero, carry, error);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        input1 = 32'd100;
        input2 = 32'd7;
        op     = 4'b0001;
        x = model(32'd100, 32'd7, 4'b0001);
        @(posedge clk);
        #1;
        n_cmp++;
        if ({output1, zero, carry, error} !== x) begin
            n_fail++;
            $display("FAIL async_resume: got %h_%b%b%b, want %h_%b%b%b",
                     output1, zero, carry, error, x.r, x.z, x.c, x.e);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add_sub();
        test_mul_div();
        test_div_zero();
        test_illegal();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
